xalu_seq: RTL and testbench
===========================

Name: xalu_seq

Overview:
- Multi-cycle multiply/divide sequencer with the HI/LO register pair, sitting in the E stage beside the main ALU.
- Accepts the 4-bit xaluop issued by the decoder and runs mult/multu/div/divu/madd over a fixed number of cycles.
- Owns HI/LO and handles mthi/mtlo writes.
- Generates the stall request that holds the D stage while the unit is in use.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd (legal range 1-15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1-15).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- xaluop  in  4  E-stage op: 9 madd, 8 mfhi, 7 mflo, 6 mult, 5 multu, 4 div, 3 divu, 2 mthi, 1 mtlo, 0 none.
- issue  in  1  E-stage instruction valid (not bubble/flushed); gates xaluop.
- a  in  32  rs operand (forwarded).
- b  in  32  rt operand (forwarded).
- d_uses_xalu  in  1  D-stage instruction has nonzero xaluop.
- start  out  1  combinational: issue & IDLE & op in {9,6,5,4,3}.
- busy  out  1  registered: operation in flight.
- stall_req  out  1  combinational: d_uses_xalu & (start | busy).
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - State goes to IDLE, counter 0, busy 0, hi 0, lo 0, pending result discarded.
  - start and stall_req are 0 whenever issue/d_uses_xalu are 0.
- FSM has two states, IDLE and BUSY.
- IDLE, on start:
  - Latch the op and compute the 64-bit result into the pending registers.
  - Load cnt = MULT_CYCLES or DIV_CYCLES; go to BUSY.
- BUSY:
  - busy = 1; cnt decrements every edge.
  - At the edge where cnt == 1: write pending to hi/lo, clear busy, go to IDLE.
  - Timing: accepted at edge t gives busy high for cycles t+1..t+N; new hi/lo are visible from cycle t+N+1.
- Results (pending):
  - mult: {hi,lo} = signed a*b.
  - multu: {hi,lo} = unsigned a*b.
  - madd: {hi,lo} = {hi,lo} + signed a*b, mod 2^64, using the hi/lo values at acceptance.
  - div: lo = quotient, hi = remainder. Signed, quotient truncates toward zero, remainder takes the sign of a.
  - divu: same as div, unsigned.
- Division boundaries:
  - b == 0: lo = 0xFFFFFFFF, hi = a, for both div and divu.
  - div with a = 0x80000000, b = 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- mthi/mtlo:
  - In IDLE with issue: hi (or lo) <= a at that edge, single cycle, busy stays 0.
- mfhi/mflo:
  - No state change; the datapath reads the hi/lo outputs directly.
  - Correctness relies on stall_req having held the instruction in D until IDLE.
- Issue while BUSY (any nonzero op) is a protocol violation, because stall_req prevents it.
  - The unit ignores it: no state change, and the in-flight operation completes unaffected.
- issue = 0 or xaluop = 0: no effect.
- Undefined codes 10-15 are treated as none.
- Back-to-back: an op issued in the cycle after busy falls is accepted normally, with no dead cycle.
- stall_req is asserted in the start cycle so that a dependent D-stage mfhi/mflo or mult cannot advance in the same cycle.
- The unit never stalls on its own; pipeline freeze is the upstream hazard unit's job via stall_req.

Test Plan:
- mult, a = 0xFFFFFFFE (-2), b = 3 -> start = 1 one cycle, busy high exactly 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA; hi/lo unchanged before that.
- multu, a = 0xFFFFFFFF, b = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001 after 5 busy cycles.
- div, a = -7 (0xFFFFFFF9), b = 2 -> 10 busy cycles, lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- div, b = 0 -> lo = 0xFFFFFFFF, hi = a.
- div, 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- mthi a = 0x12345678, then madd a = 2, b = 3 with lo = 0xFFFFFFFF -> hi = 0x12345679, lo = 0x00000005.
- d_uses_xalu = 1 (mflo) during the start cycle and every busy cycle -> stall_req = 1 throughout, dropping to 0 the cycle busy falls.
- Issue divu while busy -> ignored, original result intact.
- Assert reset at busy cycle 3 of a div -> busy = 0, hi = lo = 0 immediately (asynchronous); no late write after reset release.

Source files
------------

// File: rtl/xalu_seq.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair.
// The result is computed at acceptance and held in pending registers until the busy window expires.
module xalu_seq #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  xaluop,
    input  logic        issue,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_uses_xalu,
    output logic        start,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MTLO  = 4'd1,
        OP_MTHI  = 4'd2,
        OP_DIVU  = 4'd3,
        OP_DIV   = 4'd4,
        OP_MULTU = 4'd5,
        OP_MULT  = 4'd6,
        OP_MFLO  = 4'd7,
        OP_MFHI  = 4'd8,
        OP_MADD  = 4'd9
    } xop_t;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        busy_nx;
    logic [31:0] pend_hi, pend_lo, pend_hi_nx, pend_lo_nx;
    logic [31:0] hi_nx, lo_nx;

    logic        is_long_op;
    logic        is_div_op;

    assign is_long_op = xaluop inside {OP_MADD, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    assign is_div_op  = xaluop inside {OP_DIV, OP_DIVU};
    assign start      = issue && (state == IDLE) && is_long_op;
    assign stall_req  = d_uses_xalu && (start || busy);

    // Multiply datapath
    logic [63:0] prod_s, prod_u, madd_sum;

    assign prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u   = {32'd0, a} * {32'd0, b};
    assign madd_sum = {hi, lo} + prod_s;

    // Signed division runs on magnitudes; INT_MIN / -1 then wraps to INT_MIN with remainder 0.
    logic [31:0] abs_a, abs_b, mag_q, mag_r, sdiv_q, sdiv_r, udiv_q, udiv_r;

    assign abs_a  = a[31] ? -a : a;
    assign abs_b  = b[31] ? -b : b;
    assign mag_q  = (abs_b == 32'd0) ? 32'd0 : abs_a / abs_b;
    assign mag_r  = (abs_b == 32'd0) ? 32'd0 : abs_a % abs_b;
    assign sdiv_q = (a[31] ^ b[31]) ? -mag_q : mag_q;
    assign sdiv_r = a[31] ? -mag_r : mag_r;
    assign udiv_q = (b == 32'd0) ? 32'd0 : a / b;
    assign udiv_r = (b == 32'd0) ? 32'd0 : a % b;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_nx   = state;
        cnt_nx     = cnt;
        busy_nx    = busy;
        pend_hi_nx = pend_hi;
        pend_lo_nx = pend_lo;
        hi_nx      = hi;
        lo_nx      = lo;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = BUSY;
                    busy_nx  = 1'b1;
                    cnt_nx   = is_div_op ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    unique case (xop_t'(xaluop))
                        OP_MULT:  {pend_hi_nx, pend_lo_nx} = prod_s;
                        OP_MULTU: {pend_hi_nx, pend_lo_nx} = prod_u;
                        OP_MADD:  {pend_hi_nx, pend_lo_nx} = madd_sum;
                        OP_DIV: begin
                            pend_hi_nx = (b == 32'd0) ? a : sdiv_r;
                            pend_lo_nx = (b == 32'd0) ? 32'hFFFF_FFFF : sdiv_q;
                        end
                        OP_DIVU: begin
                            pend_hi_nx = (b == 32'd0) ? a : udiv_r;
                            pend_lo_nx = (b == 32'd0) ? 32'hFFFF_FFFF : udiv_q;
                        end
                        default: ;
                    endcase
                end else if (issue && (xaluop == OP_MTHI)) begin
                    hi_nx = a;
                end else if (issue && (xaluop == OP_MTLO)) begin
                    lo_nx = a;
                end
            end
            BUSY: begin
                // Any issue here is a protocol violation and is deliberately ignored.
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    hi_nx    = pend_hi;
                    lo_nx    = pend_lo;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            busy    <= 1'b0;
            // NOTE: pending registers are reset too, so nothing in flight survives an abort.
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            busy    <= busy_nx;
            pend_hi <= pend_hi_nx;
            pend_lo <= pend_lo_nx;
            hi      <= hi_nx;
            lo      <= lo_nx;
        end
    end

endmodule

// File: tb/tb_xalu_seq.sv
// Self-checking bench for xalu_seq: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed HI/LO and timing expectations.
module tb_xalu_seq;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  xaluop = 4'd0;
    logic        issue = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        d_uses_xalu = 1'b0;
    logic        start, busy, stall_req;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    xalu_seq #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .xaluop(xaluop), .issue(issue), .a(a), .b(b),
        .d_uses_xalu(d_uses_xalu), .start(start), .busy(busy), .stall_req(stall_req),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: remaining busy cycles plus the result computed with plain arithmetic.
    int          m_left = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;

    function automatic logic is_long(input logic [3:0] op);
        return (op == 4'd9) || (op == 4'd6) || (op == 4'd5) || (op == 4'd4) || (op == 4'd3);
    endfunction

    function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] av,
                                                 input logic [31:0] bv, input logic [31:0] h,
                                                 input logic [31:0] l);
        longint sa, sb, ua, ub, q, r;
        logic [63:0] res;
        sa  = longint'(signed'(av));
        sb  = longint'(signed'(bv));
        ua  = longint'({32'd0, av});
        ub  = longint'({32'd0, bv});
        res = 64'd0;
        case (op)
            4'd6: res = 64'(sa * sb);
            4'd5: res = {32'd0, av} * {32'd0, bv};
            4'd9: res = {h, l} + 64'(sa * sb);
            4'd4, 4'd3: begin
                if (bv == 32'd0) begin
                    res = {av, 32'hFFFF_FFFF};
                end else begin
                    q   = (op == 4'd4) ? sa / sb : ua / ub;
                    r   = (op == 4'd4) ? sa % sb : ua % ub;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = {h, l};
        endcase
        return res;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (issue) begin
            if (is_long(xaluop)) begin
                {m_phi, m_plo} = model_result(xaluop, a, b, m_hi, m_lo);
                m_left = (xaluop == 4'd4 || xaluop == 4'd3) ? DIV_N : MULT_N;
            end else if (xaluop == 4'd2) begin
                m_hi = a;
            end else if (xaluop == 4'd1) begin
                m_lo = a;
            end
        end
    end

    // Compare mid-cycle: state reflects the last edge, inputs are those for the next edge.
    always @(negedge clk) begin
        logic exp_start;
        exp_start = issue && (m_left == 0) && is_long(xaluop);
        check("cmp_start", {63'd0, start}, {63'd0, exp_start});
        check("cmp_busy", {63'd0, busy}, {63'd0, m_left > 0});
        check("cmp_stall_req", {63'd0, stall_req}, {63'd0, d_uses_xalu && (exp_start || m_left > 0)});
        check("cmp_hi", {32'd0, hi}, {32'd0, m_hi});
        check("cmp_lo", {32'd0, lo}, {32'd0, m_lo});
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic iss, input logic d);
        xaluop      = op;
        a           = av;
        b           = bv;
        issue       = iss;
        d_uses_xalu = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n, input logic d);
        n = 0;
        while (busy && n < 40) begin
            drive(4'd0, 32'd0, 32'd0, 1'b0, d);
            n++;
        end
        if (n >= 40) check("wait_idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);

        // mult -2 * 3
        xaluop = 4'd6; issue = 1'b1; a = 32'hFFFF_FFFE; b = 32'd3; d_uses_xalu = 1'b0;
        #1;
        check("mult_start", {63'd0, start}, 64'd1);
        @(posedge clk);
        #1;
        check("mult_hi_hold", {32'd0, hi}, 64'd0);
        wait_idle(n, 1'b0);
        check("mult_busy_cycles", 64'(n), 64'd5);
        check("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        check("mult_lo", {32'd0, lo}, 64'hFFFF_FFFA);

        drive(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_idle(n, 1'b0);
        check("multu_hi", {32'd0, hi}, 64'hFFFF_FFFE);
        check("multu_lo", {32'd0, lo}, 64'h0000_0001);

        drive(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        wait_idle(n, 1'b0);
        check("div_busy_cycles", 64'(n), 64'd10);
        check("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        check("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);

        drive(4'd4, 32'h0000_1234, 32'd0, 1'b1, 1'b0);
        wait_idle(n, 1'b0);
        check("div0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        check("div0_hi", {32'd0, hi}, 64'h0000_1234);

        drive(4'd3, 32'h0000_ABCD, 32'd0, 1'b1, 1'b0);
        wait_idle(n, 1'b0);
        check("divu0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        check("divu0_hi", {32'd0, hi}, 64'h0000_ABCD);

        drive(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_idle(n, 1'b0);
        check("divovf_lo", {32'd0, lo}, 64'h8000_0000);
        check("divovf_hi", {32'd0, hi}, 64'd0);

        // mthi / mtlo back-to-back, then madd accumulates onto them
        drive(4'd2, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
        check("mthi_no_busy", {63'd0, busy}, 64'd0);
        drive(4'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        drive(4'd9, 32'd2, 32'd3, 1'b1, 1'b0);
        wait_idle(n, 1'b0);
        check("madd_hi", {32'd0, hi}, 64'h1234_5679);
        check("madd_lo", {32'd0, lo}, 64'h0000_0005);

        // dependent mflo waiting in D across the whole operation
        xaluop = 4'd6; issue = 1'b1; a = 32'd5; b = 32'd7; d_uses_xalu = 1'b1;
        #1;
        check("stall_start_cycle", {63'd0, stall_req}, 64'd1);
        @(posedge clk);
        #1;
        wait_idle(n, 1'b1);
        check("stall_busy_cycles", 64'(n), 64'd5);
        check("stall_drop", {63'd0, stall_req}, 64'd0);
        check("stall_mult_lo", {32'd0, lo}, 64'd35);

        // accepted immediately after busy falls, then a divu and mthi issued illegally while busy
        drive(4'd4, 32'd100, 32'd7, 1'b1, 1'b0);
        check("b2b_accept", {63'd0, busy}, 64'd1);
        drive(4'd3, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        drive(4'd2, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
        wait_idle(n, 1'b0);
        check("ignore_busy_cycles", 64'(n), 64'd8);
        check("ignore_lo", {32'd0, lo}, 64'd14);
        check("ignore_hi", {32'd0, hi}, 64'd2);

        // undefined code and a non-issued op have no effect
        drive(4'd12, 32'h5555_5555, 32'd3, 1'b1, 1'b0);
        check("undef_no_busy", {63'd0, busy}, 64'd0);
        drive(4'd6, 32'd9, 32'd9, 1'b0, 1'b0);
        check("noissue_no_busy", {63'd0, busy}, 64'd0);
        check("noissue_lo", {32'd0, lo}, 64'd14);

        // asynchronous reset in busy cycle 3 of a div
        drive(4'd4, 32'd1000, 32'd3, 1'b1, 1'b0);
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("areset_busy", {63'd0, busy}, 64'd0);
        check("areset_hi", {32'd0, hi}, 64'd0);
        check("areset_lo", {32'd0, lo}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (12) drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("no_late_hi", {32'd0, hi}, 64'd0);
        check("no_late_lo", {32'd0, lo}, 64'd0);

        drive(4'd6, 32'd3, 32'd4, 1'b1, 1'b0);
        wait_idle(n, 1'b0);
        check("recover_lo", {32'd0, lo}, 64'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
